// File: rtl/pipelined_adder.sv
// -----------------------------------------------------------------------------
// pipelined_adder
//   WIDTH-bit adder/subtractor whose carry chain is cut into STAGES slices of
//   CHUNK = WIDTH/STAGES bits. Each slice resolves its own CHUNK bits in one
//   cycle and hands its carry to the next slice. A single global advance
//   signal moves every slice at once. Results therefore leave in acceptance
//   order, and the no-stall latency is exactly STAGES cycles.
//
//   Legal parameter values: WIDTH >= 2, STAGES >= 1, and STAGES must divide
//   WIDTH exactly.
//
// Ports
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset; drops every in-flight beat
//   in_valid   operand beat present on a/b/sub/cin
//   in_ready   block accepts a beat this cycle (equals advance)
//   a, b       WIDTH-bit operands, unsigned or two's complement
//   sub        0: a + b + cin    1: a - b - cin
//   cin        carry-in (sub=0) or borrow-in (sub=1)
//   out_valid  result beat present on sum/cout/ovf
//   out_ready  downstream accepts the result
//   sum        result modulo 2^WIDTH
//   cout       carry-out; for subtraction 1 means no borrow
//   ovf        signed two's-complement overflow
// -----------------------------------------------------------------------------
module pipelined_adder #(
    parameter int WIDTH  = 8,
    parameter int STAGES = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             sub,
    input  logic             cin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf
);

    localparam int CHUNK = WIDTH / STAGES;
    localparam int MSB   = WIDTH - 1;

    // Signed overflow: both addends share a sign and the result's sign
    // differs from it. The addend here is the already inverted operand.
    function automatic logic ovf_calc(input logic a_msb, input logic bb_msb,
                                      input logic s_msb);
        return (a_msb == bb_msb) && (s_msb != a_msb);
    endfunction

    logic             advance;
    logic [WIDTH-1:0] bb_head;
    logic             c0;

    // Subtraction is done as a + ~b + 1. The incoming borrow cancels the +1.
    assign bb_head  = sub ? ~b : b;
    assign c0       = cin ^ sub;
    assign advance  = !out_valid || out_ready;
    assign in_ready = advance;

    // Slice k inputs (from the ports for k=0, otherwise from slice k-1's
    // registers) and the value each slice would register this cycle.
    logic [STAGES-1:0][WIDTH-1:0] a_in;
    logic [STAGES-1:0][WIDTH-1:0] bb_in;
    logic [STAGES-1:0][WIDTH-1:0] sm_in;
    logic [STAGES-1:0]            c_in;
    logic [STAGES-1:0]            v_in;
    logic [STAGES-1:0][WIDTH-1:0] sm_nx;
    logic [STAGES-1:0]            c_nx;

    // Per-slice pipeline registers: operands still to be processed, result
    // bits resolved so far, and the carry into the next slice.
    logic [STAGES-1:0][WIDTH-1:0] a_p;
    logic [STAGES-1:0][WIDTH-1:0] bb_p;
    logic [STAGES-1:0][WIDTH-1:0] sm_p;
    logic [STAGES-1:0]            cy_p;
    logic [STAGES-1:0]            vld_p;

    for (genvar k = 0; k < STAGES; k++) begin : g_slice
        logic [CHUNK:0] part;

        if (k == 0) begin : g_head
            assign a_in[k]  = a;
            assign bb_in[k] = bb_head;
            assign sm_in[k] = '0;
            assign c_in[k]  = c0;
            assign v_in[k]  = in_valid;
        end else begin : g_body
            assign a_in[k]  = a_p[k-1];
            assign bb_in[k] = bb_p[k-1];
            assign sm_in[k] = sm_p[k-1];
            assign c_in[k]  = cy_p[k-1];
            assign v_in[k]  = vld_p[k-1];
        end

        assign part = {1'b0, a_in[k][k*CHUNK +: CHUNK]}
                    + {1'b0, bb_in[k][k*CHUNK +: CHUNK]}
                    + {{CHUNK{1'b0}}, c_in[k]};

        // Bits above the slices resolved so far are always zero, so OR-ing
        // in this slice's chunk is enough to merge it.
        assign sm_nx[k] = sm_in[k] | (WIDTH'(part[CHUNK-1:0]) << (k * CHUNK));
        assign c_nx[k]  = part[CHUNK];
    end

    // ---- slice registers (data: loaded only for valid beats) ----
    always_ff @(posedge clk) begin
        for (int k = 0; k < STAGES; k++) begin
            if (advance && v_in[k]) begin
                a_p[k]  <= a_in[k];
                bb_p[k] <= bb_in[k];
                sm_p[k] <= sm_nx[k];
                cy_p[k] <= c_nx[k];
            end
        end
    end

    // ---- slice valid flags: the whole chain shifts on advance ----
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_p <= '0;
        end else if (advance) begin
            vld_p <= v_in;
        end
    end

    // ---- output registers, loaded straight from the last slice ----
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sum  <= '0;
            cout <= 1'b0;
            ovf  <= 1'b0;
        end else if (advance && v_in[STAGES-1]) begin
            sum  <= sm_nx[STAGES-1];
            cout <= c_nx[STAGES-1];
            ovf  <= ovf_calc(a_in[STAGES-1][MSB], bb_in[STAGES-1][MSB],
                             sm_nx[STAGES-1][MSB]);
        end
    end

    assign out_valid = vld_p[STAGES-1];

    // Each slice reads only part of its predecessor's operand registers, and
    // the last slice's own register copy feeds nothing (the output registers
    // take its place). Gathering them here keeps those partly read fields
    // from reading as dead logic; synthesis trims the bits nobody uses.
    logic unused_pipe;
    assign unused_pipe = ^{a_p, bb_p, sm_p, cy_p, a_in, bb_in};

endmodule

// File: tb/tb_pipelined_adder.sv
module tb_pipelined_adder;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_n;

    // Main instance: WIDTH=8, STAGES=2
    logic       in_valid, in_ready, sub, cin, out_valid, out_ready, cout, ovf;
    logic [7:0] a, b, sum;

    pipelined_adder #(.WIDTH(8), .STAGES(2)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .sub(sub), .cin(cin), .out_valid(out_valid),
        .out_ready(out_ready), .sum(sum), .cout(cout), .ovf(ovf));

    // Sweep instance: WIDTH=16, STAGES=4
    logic        w16_in_valid, w16_in_ready, w16_sub, w16_cin;
    logic        w16_out_valid, w16_out_ready, w16_cout, w16_ovf;
    logic [15:0] w16_a, w16_b, w16_sum;

    pipelined_adder #(.WIDTH(16), .STAGES(4)) dut16 (
        .clk(clk), .rst_n(rst_n), .in_valid(w16_in_valid), .in_ready(w16_in_ready),
        .a(w16_a), .b(w16_b), .sub(w16_sub), .cin(w16_cin), .out_valid(w16_out_valid),
        .out_ready(w16_out_ready), .sum(w16_sum), .cout(w16_cout), .ovf(w16_ovf));

    // Sweep instance: WIDTH=4, STAGES=1
    logic       w4_in_valid, w4_in_ready, w4_sub, w4_cin;
    logic       w4_out_valid, w4_out_ready, w4_cout, w4_ovf;
    logic [3:0] w4_a, w4_b, w4_sum;

    pipelined_adder #(.WIDTH(4), .STAGES(1)) dut4 (
        .clk(clk), .rst_n(rst_n), .in_valid(w4_in_valid), .in_ready(w4_in_ready),
        .a(w4_a), .b(w4_b), .sub(w4_sub), .cin(w4_cin), .out_valid(w4_out_valid),
        .out_ready(w4_out_ready), .sum(w4_sum), .cout(w4_cout), .ovf(w4_ovf));

    int checks   = 0;
    int failures = 0;

    // Reference: {ovf, cout, sum}
    function automatic logic [17:0] model16(input logic [15:0] x, input logic [15:0] y,
                                            input logic s, input logic c);
        logic [15:0] yy;
        logic [16:0] full;
        yy   = s ? ~y : y;
        full = {1'b0, x} + {1'b0, yy} + {16'd0, c ^ s};
        return {(x[15] == yy[15]) && (full[15] != x[15]), full};
    endfunction

    function automatic logic [5:0] model4(input logic [3:0] x, input logic [3:0] y,
                                          input logic s, input logic c);
        logic [3:0] yy;
        logic [4:0] full;
        yy   = s ? ~y : y;
        full = {1'b0, x} + {1'b0, yy} + {4'd0, c ^ s};
        return {(x[3] == yy[3]) && (full[3] != x[3]), full};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [7:0] xa, input logic [7:0] xb,
                         input logic xs, input logic xc);
        in_valid = v;
        a        = xa;
        b        = xb;
        sub      = xs;
        cin      = xc;
    endtask

    task automatic test_reset();
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if (out_valid !== 1'b0) begin failures++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
        checks++;
        if (sum !== 8'h00) begin failures++; $display("FAIL reset_sum: got %h want 00", sum); end
        checks++;
        if (cout !== 1'b0) begin failures++; $display("FAIL reset_cout: got %b want 0", cout); end
        checks++;
        if (ovf !== 1'b0) begin failures++; $display("FAIL reset_ovf: got %b want 0", ovf); end
        rst_n = 1'b1;
        tick();
        checks++;
        if (in_ready !== 1'b1) begin failures++; $display("FAIL reset_in_ready: got %b want 1", in_ready); end
        checks++;
        if (out_valid !== 1'b0) begin failures++; $display("FAIL reset_release_valid: got %b want 0", out_valid); end
        out_ready = 1'b1;
    endtask

    task automatic test_back_to_back();
        logic [7:0] va[3];
        logic [7:0] vb[3];
        logic [7:0] es[3];
        logic       ec[3];
        logic       exp_v;
        va = '{8'h05, 8'h0A, 8'hFF};
        vb = '{8'h05, 8'h05, 8'h01};
        es = '{8'h0A, 8'h0F, 8'h00};
        ec = '{1'b0, 1'b0, 1'b1};
        out_ready = 1'b1;
        for (int c = 0; c < 5; c++) begin
            if (c < 3) drive(1'b1, va[c], vb[c], 1'b0, 1'b0);
            else       drive(1'b0, 8'h00, 8'h00, 1'b0, 1'b0);
            tick();
            // now at cycle c+1; results expected on cycles 2, 3, 4
            exp_v = (c >= 1) && (c <= 3);
            checks++;
            if (out_valid !== exp_v) begin
                failures++;
                $display("FAIL b2b_valid_cycle%0d: got %b want %b", c + 1, out_valid, exp_v);
            end
            if (exp_v) begin
                checks++;
                if ({cout, sum} !== {ec[c-1], es[c-1]}) begin
                    failures++;
                    $display("FAIL b2b_result%0d: got cout=%b sum=%h want cout=%b sum=%h",
                             c - 1, cout, sum, ec[c-1], es[c-1]);
                end
            end
        end
    endtask

    task automatic test_subtraction();
        logic [7:0] va[3];
        logic [7:0] vb[3];
        logic       vc[3];
        logic [7:0] es[3];
        logic       ec[3];
        va = '{8'h10, 8'h00, 8'h05};
        vb = '{8'h01, 8'h01, 8'h05};
        vc = '{1'b0, 1'b0, 1'b1};
        es = '{8'h0F, 8'hFF, 8'hFF};
        ec = '{1'b1, 1'b0, 1'b0};
        out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, va[i], vb[i], 1'b1, vc[i]);
            tick();
            drive(1'b0, 8'h00, 8'h00, 1'b0, 1'b0);
            tick();
            checks++;
            if ({out_valid, cout, sum, ovf} !== {1'b1, ec[i], es[i], 1'b0}) begin
                failures++;
                $display("FAIL sub%0d: got v=%b cout=%b sum=%h ovf=%b want v=1 cout=%b sum=%h ovf=0",
                         i, out_valid, cout, sum, ovf, ec[i], es[i]);
            end
        end
        tick();
    endtask

    task automatic test_overflow();
        logic [7:0] va[3];
        logic [7:0] vb[3];
        logic       vs[3];
        logic [7:0] es[3];
        logic       ec[3];
        logic       eo[3];
        va = '{8'h7F, 8'h80, 8'hFF};
        vb = '{8'h01, 8'h01, 8'h01};
        vs = '{1'b0, 1'b1, 1'b0};
        es = '{8'h80, 8'h7F, 8'h00};
        ec = '{1'b0, 1'b1, 1'b1};
        eo = '{1'b1, 1'b1, 1'b0};
        out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, va[i], vb[i], vs[i], 1'b0);
            tick();
            drive(1'b0, 8'h00, 8'h00, 1'b0, 1'b0);
            tick();
            checks++;
            if ({out_valid, cout, sum, ovf} !== {1'b1, ec[i], es[i], eo[i]}) begin
                failures++;
                $display("FAIL ovf%0d: got v=%b cout=%b sum=%h ovf=%b want v=1 cout=%b sum=%h ovf=%b",
                         i, out_valid, cout, sum, ovf, ec[i], es[i], eo[i]);
            end
        end
        tick();
    endtask

    task automatic test_backpressure();
        out_ready = 1'b0;
        drive(1'b1, 8'h11, 8'h22, 1'b0, 1'b0);
        tick();
        drive(1'b1, 8'h40, 8'h41, 1'b0, 1'b0);
        tick();
        drive(1'b1, 8'hF0, 8'h20, 1'b0, 1'b0);
        for (int i = 0; i < 5; i++) begin
            checks++;
            if (in_ready !== 1'b0) begin failures++; $display("FAIL bp_in_ready%0d: got %b want 0", i, in_ready); end
            checks++;
            if ({out_valid, cout, sum} !== {1'b1, 1'b0, 8'h33}) begin
                failures++;
                $display("FAIL bp_hold%0d: got v=%b cout=%b sum=%h want v=1 cout=0 sum=33", i, out_valid, cout, sum);
            end
            tick();
        end
        out_ready = 1'b1;
        #1;
        checks++;
        if (in_ready !== 1'b1) begin failures++; $display("FAIL bp_release_ready: got %b want 1", in_ready); end
        checks++;
        if ({out_valid, cout, sum} !== {1'b1, 1'b0, 8'h33}) begin
            failures++;
            $display("FAIL bp_out0: got v=%b cout=%b sum=%h want v=1 cout=0 sum=33", out_valid, cout, sum);
        end
        tick();
        drive(1'b0, 8'h00, 8'h00, 1'b0, 1'b0);
        checks++;
        if ({out_valid, cout, sum} !== {1'b1, 1'b0, 8'h81}) begin
            failures++;
            $display("FAIL bp_out1: got v=%b cout=%b sum=%h want v=1 cout=0 sum=81", out_valid, cout, sum);
        end
        tick();
        checks++;
        if ({out_valid, cout, sum} !== {1'b1, 1'b1, 8'h10}) begin
            failures++;
            $display("FAIL bp_out2: got v=%b cout=%b sum=%h want v=1 cout=1 sum=10", out_valid, cout, sum);
        end
        tick();
        checks++;
        if (out_valid !== 1'b0) begin failures++; $display("FAIL bp_drained: got %b want 0", out_valid); end
    endtask

    task automatic test_mid_reset();
        out_ready = 1'b1;
        drive(1'b1, 8'h01, 8'h01, 1'b0, 1'b0);
        tick();
        drive(1'b1, 8'h02, 8'h02, 1'b0, 1'b0);
        tick();
        drive(1'b0, 8'h00, 8'h00, 1'b0, 1'b0);
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if (out_valid !== 1'b0) begin failures++; $display("FAIL mrst_valid: got %b want 0", out_valid); end
        checks++;
        if (sum !== 8'h00) begin failures++; $display("FAIL mrst_sum: got %h want 00", sum); end
        tick();
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++;
            if (out_valid !== 1'b0) begin failures++; $display("FAIL mrst_stale%0d: got %b want 0", i, out_valid); end
        end
        checks++;
        if (in_ready !== 1'b1) begin failures++; $display("FAIL mrst_in_ready: got %b want 1", in_ready); end
        drive(1'b1, 8'h03, 8'h04, 1'b0, 1'b0);
        tick();
        drive(1'b0, 8'h00, 8'h00, 1'b0, 1'b0);
        checks++;
        if (out_valid !== 1'b0) begin failures++; $display("FAIL mrst_early: got %b want 0", out_valid); end
        tick();
        checks++;
        if ({out_valid, cout, sum} !== {1'b1, 1'b0, 8'h07}) begin
            failures++;
            $display("FAIL mrst_result: got v=%b cout=%b sum=%h want v=1 cout=0 sum=07", out_valid, cout, sum);
        end
        tick();
    endtask

    task automatic test_sweep();
        logic [17:0] q16[$];
        logic [5:0]  q4[$];
        logic [17:0] e16;
        logic [5:0]  e4;
        for (int cyc = 0; cyc < 2010; cyc++) begin
            if (cyc < 2000) begin
                w16_in_valid  = ($urandom_range(0, 3) != 0);
                w16_out_ready = ($urandom_range(0, 3) != 0);
                w16_a   = 16'($urandom());
                w16_b   = 16'($urandom());
                w16_sub = 1'($urandom());
                w16_cin = 1'($urandom());
                w4_in_valid  = ($urandom_range(0, 3) != 0);
                w4_out_ready = ($urandom_range(0, 3) != 0);
                w4_a   = 4'($urandom());
                w4_b   = 4'($urandom());
                w4_sub = 1'($urandom());
                w4_cin = 1'($urandom());
            end else begin
                w16_in_valid  = 1'b0;
                w16_out_ready = 1'b1;
                w4_in_valid   = 1'b0;
                w4_out_ready  = 1'b1;
            end
            #1;
            if (w16_out_valid && w16_out_ready) begin
                checks++;
                if (q16.size() == 0) begin
                    failures++;
                    $display("FAIL sweep16_spurious: got out_valid=1 sum=%h want no beat", w16_sum);
                end else begin
                    e16 = q16.pop_front();
                    if ({w16_ovf, w16_cout, w16_sum} !== e16) begin
                        failures++;
                        $display("FAIL sweep16_cyc%0d: got ovf=%b cout=%b sum=%h want ovf=%b cout=%b sum=%h",
                                 cyc, w16_ovf, w16_cout, w16_sum, e16[17], e16[16], e16[15:0]);
                    end
                end
            end
            if (w16_in_valid && w16_in_ready) q16.push_back(model16(w16_a, w16_b, w16_sub, w16_cin));
            if (w4_out_valid && w4_out_ready) begin
                checks++;
                if (q4.size() == 0) begin
                    failures++;
                    $display("FAIL sweep4_spurious: got out_valid=1 sum=%h want no beat", w4_sum);
                end else begin
                    e4 = q4.pop_front();
                    if ({w4_ovf, w4_cout, w4_sum} !== e4) begin
                        failures++;
                        $display("FAIL sweep4_cyc%0d: got ovf=%b cout=%b sum=%h want ovf=%b cout=%b sum=%h",
                                 cyc, w4_ovf, w4_cout, w4_sum, e4[5], e4[4], e4[3:0]);
                    end
                end
            end
            if (w4_in_valid && w4_in_ready) q4.push_back(model4(w4_a, w4_b, w4_sub, w4_cin));
            @(posedge clk);
            #1;
        end
        checks++;
        if (q16.size() != 0) begin failures++; $display("FAIL sweep16_lost: got %0d undelivered want 0", q16.size()); end
        checks++;
        if (q4.size() != 0) begin failures++; $display("FAIL sweep4_lost: got %0d undelivered want 0", q4.size()); end
    endtask

    initial begin
        rst_n     = 1'b0;
        out_ready = 1'b0;
        drive(1'b0, 8'h00, 8'h00, 1'b0, 1'b0);
        w16_in_valid = 1'b0; w16_out_ready = 1'b1; w16_a = '0; w16_b = '0; w16_sub = 1'b0; w16_cin = 1'b0;
        w4_in_valid  = 1'b0; w4_out_ready  = 1'b1; w4_a  = '0; w4_b  = '0; w4_sub  = 1'b0; w4_cin  = 1'b0;
        test_reset();
        test_back_to_back();
        test_subtraction();
        test_overflow();
        test_backpressure();
        test_mid_reset();
        test_sweep();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
